// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter
// Description : Round-robin arbiter with a registered one-hot grant that
//               drives the enable bus of a one-hot AND-OR output mux. A grant
//               lasts a whole transfer and ends on the last beat, when the
//               requester drops its request, or when the hold timeout expires.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int NUM     = 4,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM-1:0]          req_bus,
    input  logic [NUM-1:0]          last_bus,
    input  logic                    out_ready,
    output logic [NUM-1:0]          grant_bus,
    output logic [$clog2(NUM)-1:0]  grant_idx,
    output logic                    busy,
    output logic                    beat,
    output logic                    timeout_err
);

    localparam int IDX_W = $clog2(NUM);

    // Hold-counter value on the last cycle a grant may be held (unused when TIMEOUT==0)
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state,       w_state_nx;
    logic [NUM-1:0]     r_grant_bus,   w_grant_bus_nx;
    logic [IDX_W-1:0]   r_grant_idx,   w_grant_idx_nx;
    logic               r_busy,        w_busy_nx;
    logic               r_timeout_err, w_timeout_err_nx;
    logic [IDX_W-1:0]   r_ptr,         w_ptr_nx;
    logic [CNT_W-1:0]   r_cnt,         w_cnt_nx;

    logic               w_beat;
    logic               w_rel_last;
    logic               w_rel_drop;
    logic               w_rel_tout;
    logic [IDX_W-1:0]   w_ptr_inc;
    logic [NUM-1:0]     w_masked;
    logic [IDX_W:0]     w_pick;

    // First set bit of vec scanning start, start+1, ..., NUM-1, 0, ..., start-1.
    // Returns {found, index}. Scanning high-to-low lets the lowest qualifying
    // bit win by being assigned last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM-1:0] vec,
                                               input logic [IDX_W-1:0] start);
        logic             hi_found;
        logic             lo_found;
        logic [IDX_W-1:0] hi_idx;
        logic [IDX_W-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM - 1; j >= 0; j--) begin
            if (vec[j]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(j);
                if (j >= int'(start)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(j);
                end
            end
        end
        return hi_found ? {1'b1, hi_idx} : {lo_found, lo_idx};
    endfunction

    // Binary index to one-hot vector
    function automatic logic [NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM-1:0] v;
        for (int j = 0; j < NUM; j++) begin
            v[j] = (IDX_W'(j) == idx);
        end
        return v;
    endfunction

    assign w_beat     = r_busy & req_bus[r_grant_idx] & out_ready;
    assign w_rel_last = w_beat & last_bus[r_grant_idx];
    assign w_rel_drop = ~req_bus[r_grant_idx];
    // A completing last beat on the final allowed cycle takes precedence over the timeout
    assign w_rel_tout = (TIMEOUT != 0) && (r_cnt == C_TO_LAST) && !w_rel_last;
    assign w_ptr_inc  = (r_grant_idx == IDX_W'(NUM - 1)) ? '0 : r_grant_idx + 1'b1;
    // The outgoing owner is excluded so it cannot immediately win again
    assign w_masked   = req_bus & ~onehot(r_grant_idx);

    // Next-state logic: arbitration in IDLE, release/re-arbitration in GRANT
    always_comb begin
        w_state_nx       = r_state;
        w_grant_bus_nx   = r_grant_bus;
        w_grant_idx_nx   = r_grant_idx;
        w_busy_nx        = r_busy;
        w_ptr_nx         = r_ptr;
        w_cnt_nx         = r_cnt;
        w_timeout_err_nx = 1'b0;
        w_pick           = '0;

        case (r_state)
            ST_IDLE: begin
                w_pick = rr_pick(req_bus, r_ptr);
                if (w_pick[IDX_W]) begin
                    w_state_nx     = ST_GRANT;
                    w_grant_idx_nx = w_pick[IDX_W-1:0];
                    w_grant_bus_nx = onehot(w_pick[IDX_W-1:0]);
                    w_busy_nx      = 1'b1;
                    w_cnt_nx       = '0;
                end
            end
            ST_GRANT: begin
                w_cnt_nx = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                if (w_rel_last || w_rel_drop || w_rel_tout) begin
                    w_ptr_nx         = w_ptr_inc;
                    w_timeout_err_nx = w_rel_tout;
                    w_cnt_nx         = '0;
                    w_pick           = rr_pick(w_masked, w_ptr_inc);
                    if (w_pick[IDX_W]) begin
                        // Hand over at the release edge with no idle bubble
                        w_grant_idx_nx = w_pick[IDX_W-1:0];
                        w_grant_bus_nx = onehot(w_pick[IDX_W-1:0]);
                    end else begin
                        w_state_nx     = ST_IDLE;
                        w_grant_bus_nx = '0;
                        w_busy_nx      = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx     = ST_IDLE;
                w_grant_bus_nx = '0;
                w_busy_nx      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state       <= ST_IDLE;
            r_grant_bus   <= '0;
            r_grant_idx   <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_ptr         <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_grant_bus   <= w_grant_bus_nx;
            r_grant_idx   <= w_grant_idx_nx;
            r_busy        <= w_busy_nx;
            r_timeout_err <= w_timeout_err_nx;
            r_ptr         <= w_ptr_nx;
            r_cnt         <= w_cnt_nx;
        end
    end

    assign grant_bus   = r_grant_bus;
    assign grant_idx   = r_grant_idx;
    assign busy        = r_busy;
    assign beat        = w_beat;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter directly upstream of the one-hot AND-OR output multiplexer.
- Accepts NUM request lines and issues a registered one-hot grant. The grant drives the mux enable bus directly.
- A grant is held for a whole transfer, which ends on the granted source's last beat, a request drop, or a hold timeout.
- Guarantees at most one enable is ever active, so the downstream OR tree never merges two sources.

Parameters:
- NUM, 4, number of requesting sources; must be ≥2.
- TIMEOUT, 256, maximum cycles one grant may be held without a completing last beat; 0 disables the timeout.
- CNT_W, 9, hold-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  single clock, rising edge.
- n_rst  input  1  synchronous reset, active-low.
- req_bus  input  NUM  per-source request; must stay high for the whole transfer.
- last_bus  input  NUM  per-source last-beat flag; only sampled for the granted source.
- out_ready  input  1  downstream accepts a beat this cycle.
- grant_bus  output  NUM  registered one-hot grant; drives the mux enable bus.
- grant_idx  output  $clog2(NUM)  binary index of the granted source; valid while busy=1.
- busy  output  1  a grant is active.
- beat  output  1  combinational; equals busy & req_bus[grant_idx] & out_ready.
- timeout_err  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - grant_bus=0, grant_idx=0, busy=0, timeout_err=0.
  - Round-robin pointer ptr=0, hold counter=0.
  - State returns to IDLE. Reset mid-grant drops the grant immediately at that edge.
- States: IDLE and GRANT.
- IDLE:
  - If req_bus≠0, select winner w = first set bit scanning ptr, ptr+1, … NUM-1, 0, … ptr-1.
  - At the next edge: grant_bus=1<<w, grant_idx=w, busy=1, state=GRANT, hold counter=0.
  - Latency from request to grant is 1 cycle. If req_bus=0, stay in IDLE.
- GRANT:
  - Hold counter increments every cycle and saturates at its maximum.
  - Release conditions, evaluated each cycle on registered g=grant_idx:
    - (a) beat & last_bus[g] — normal completion.
    - (b) req_bus[g]=0 — requester abandoned.
    - (c) TIMEOUT≠0 and hold counter==TIMEOUT-1 and not (a) — forced release; timeout_err=1 for the following cycle.
  - On release, ptr←(g+1) mod NUM.
  - Re-arbitration uses the masked request vector (req_bus with bit g cleared) scanning from the new ptr. There is no idle bubble: if another source requests, the new grant is registered at the same edge as the release.
  - If the masked vector is 0, go to IDLE (grant_bus=0, busy=0).
  - g may win again only after one IDLE cycle or a turn by another source.
  - Without a release condition, the grant is held unchanged regardless of other requests (no preemption).
- Simultaneous events:
  - (a) and (c) in the same cycle counts as (a); no timeout_err.
  - (a) and (b) cannot both be true, because beat needs req_bus[g].
  - last_bus of non-granted sources is ignored.
- Invariants:
  - grant_bus is zero or exactly one-hot every cycle.
  - grant_bus[grant_idx]==busy.
  - All outputs are registered except beat.
- ptr wraps from NUM-1 to 0.

Test Plan:
- Reset then idle: n_rst=0 for 2 cycles, req_bus=0 → grant_bus=0, busy=0; after release, still 0.
- Single transfer: NUM=4, req_bus=4'b0100 at cycle 0, out_ready=1, last on the 3rd beat.
  - grant_bus=4'b0100 from cycle 1.
  - beat high on cycles 1–3.
  - grant_bus=0 at cycle 4.
- Round-robin fairness: req_bus=4'b1111 held, every transfer 1 beat with last=1.
  - Grants cycle 0001→0010→0100→1000→0001 on consecutive cycles with no bubble.
- Back-to-back with skip: ptr=1, req_bus=4'b1001.
  - Grant goes to source 3, then source 0.
  - Source 3 does not regrant while source 0 requests.
- Timeout: TIMEOUT=8, source 1 holds req, out_ready=0.
  - Grant revoked after 8 cycles in GRANT.
  - timeout_err pulses 1 cycle.
  - ptr=2; busy returns to 0 if no other requests.
- Abandon and mid-transfer reset:
  - Source 2 drops req mid-transfer → grant released next edge, no timeout_err.
  - n_rst=0 during a grant → grant_bus=0 at that edge.
